// File: rtl/mpu_program_sequencer_if.sv
// Instruction-beat stream in, MPU instruction-memory write port out.
// The sequencer sits on the slave side; the program source/MPU on the master side.
interface mpu_program_sequencer_if #(
    parameter int OPCODE_WIDTH = 25,
    parameter int AW           = 6
);
    logic                    in_valid;
    logic [OPCODE_WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    in_ready;
    logic                    write_inst_en;
    logic [OPCODE_WIDTH-1:0] write_inst_data;
    logic [AW-1:0]           write_inst_addr;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  write_inst_en,
        input  write_inst_data,
        input  write_inst_addr
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output write_inst_en,
        output write_inst_data,
        output write_inst_addr
    );
endinterface

// File: rtl/mpu_program_sequencer.sv
// Loads a program into MPU instruction memory, NOP-fills the tail,
// then releases the MPU for a fixed number of run cycles.
module mpu_program_sequencer #(
    parameter int OPCODE_WIDTH = 25,
    parameter int OPCODE_COUNT = 64,
    parameter int CNT_WIDTH    = 16,
    localparam int AW          = $clog2(OPCODE_COUNT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_start,
    input  logic [CNT_WIDTH-1:0] run_cycles,
    mpu_program_sequencer_if.slave bus,
    output logic                 mpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          load_count,
    output logic                 load_trunc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(OPCODE_COUNT - 1);

    state_t                  state;
    logic [AW-1:0]           ptr;
    logic [CNT_WIDTH-1:0]    run_lat;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    wen;
    logic [OPCODE_WIDTH-1:0] wdata;
    logic [AW-1:0]           waddr;

    // All status outputs decode straight from the state register.
    assign bus.in_ready        = (state == S_LOAD);
    assign bus.write_inst_en   = wen;
    assign bus.write_inst_data = wdata;
    assign bus.write_inst_addr = waddr;
    assign mpu_reset           = (state == S_IDLE);
    assign busy                = (state == S_LOAD) ||
                                 (state == S_FILL) ||
                                 (state == S_RUN);
    assign done                = (state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            run_lat    <= '0;
            cnt        <= '0;
            wen        <= 1'b0;
            wdata      <= '0;
            waddr      <= '0;
            load_count <= '0;
            load_trunc <= 1'b0;
        end else begin
            wen <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state      <= S_LOAD;
                        run_lat    <= run_cycles;
                        load_count <= '0;
                        load_trunc <= 1'b0;
                        ptr        <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        wen        <= 1'b1;
                        wdata      <= bus.in_data;
                        waddr      <= ptr;
                        load_count <= load_count + (AW+1)'(1);
                        // Top address closes the load whether or not in_last came.
                        if (ptr == LAST_ADDR) begin
                            load_trunc <= !bus.in_last;
                            cnt        <= run_lat;
                            state      <= (run_lat == '0) ? S_DONE : S_RUN;
                        end else begin
                            ptr <= ptr + AW'(1);
                            if (bus.in_last) begin
                                state <= S_FILL;
                            end
                        end
                    end
                end
                S_FILL: begin
                    wen   <= 1'b1;
                    wdata <= '0;
                    waddr <= ptr;
                    if (ptr == LAST_ADDR) begin
                        cnt   <= run_lat;
                        state <= (run_lat == '0) ? S_DONE : S_RUN;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_WIDTH'(1);
                    if (cnt <= CNT_WIDTH'(1)) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_program_sequencer.sv
// Directed vectors plus hand-written load/fill/run/reset sequences
// for mpu_program_sequencer at default parameters.
module tb_mpu_program_sequencer;

    localparam int OW = 25;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load_start;
    logic [15:0]   run_cycles;
    logic          mpu_reset;
    logic          busy;
    logic          done;
    logic [AW:0]   load_count;
    logic          load_trunc;

    int errors = 0;
    int checks = 0;

    mpu_program_sequencer_if #(.OPCODE_WIDTH(OW), .AW(AW)) bus ();

    mpu_program_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .run_cycles (run_cycles),
        .bus        (bus),
        .mpu_reset  (mpu_reset),
        .busy       (busy),
        .done       (done),
        .load_count (load_count),
        .load_trunc (load_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ls;
        logic [15:0]   rc;
        logic          v;
        logic [OW-1:0] d;
        logic          l;
        logic          e_rdy;
        logic          e_wen;
        logic [OW-1:0] e_wd;
        logic [AW-1:0] e_wa;
        logic          e_busy;
        logic          e_lc_chk;
        logic [AW:0]   e_lc;
    } vec_t;

    vec_t tbl [8];

    localparam logic [OW-1:0] A = 25'h0123456;
    localparam logic [OW-1:0] B = 25'h1FEDCBA;
    localparam logic [OW-1:0] C = 25'h0AAAAAA;
    localparam logic [OW-1:0] D = 25'h1555555;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] pat(input int i);
        return OW'(i * 32'h10101 + 32'h5);
    endfunction

    initial begin
        reset_n         = 1'b0;
        load_start      = 1'b0;
        run_cycles      = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;

        // ls rc v d l | rdy wen wd wa busy lc_chk lc
        tbl[0] = '{1'b1, 16'd10, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 6'd0, 1'b1, 1'b1, 7'd0};
        tbl[1] = '{1'b0, 16'd0,  1'b1, A,  1'b0, 1'b1, 1'b1, A,  6'd0, 1'b1, 1'b1, 7'd1};
        tbl[2] = '{1'b0, 16'd0,  1'b0, D,  1'b0, 1'b1, 1'b0, A,  6'd0, 1'b1, 1'b1, 7'd1};
        tbl[3] = '{1'b0, 16'd0,  1'b1, B,  1'b0, 1'b1, 1'b1, B,  6'd1, 1'b1, 1'b1, 7'd2};
        tbl[4] = '{1'b1, 16'd7,  1'b0, D,  1'b1, 1'b1, 1'b0, B,  6'd1, 1'b1, 1'b1, 7'd2};
        tbl[5] = '{1'b0, 16'd0,  1'b1, C,  1'b1, 1'b0, 1'b1, C,  6'd2, 1'b1, 1'b1, 7'd3};
        tbl[6] = '{1'b0, 16'd0,  1'b1, D,  1'b0, 1'b0, 1'b1, '0, 6'd3, 1'b1, 1'b1, 7'd3};
        tbl[7] = '{1'b0, 16'd0,  1'b0, D,  1'b0, 1'b0, 1'b1, '0, 6'd4, 1'b1, 1'b1, 7'd3};

        step();
        step();
        chk("rst mpu_reset", 32'(mpu_reset), 1);
        chk("rst in_ready", 32'(bus.in_ready), 0);
        chk("rst wen", 32'(bus.write_inst_en), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst load_count", 32'(load_count), 0);
        chk("rst load_trunc", 32'(load_trunc), 0);
        reset_n = 1'b1;
        step();
        chk("idle mpu_reset", 32'(mpu_reset), 1);

        // 3-beat program with gaps, load_start ignored while loading
        for (int i = 0; i < 8; i++) begin
            load_start   = tbl[i].ls;
            run_cycles   = tbl[i].rc;
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].d;
            bus.in_last  = tbl[i].l;
            step();
            chk($sformatf("v%0d rdy", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d wen", i), 32'(bus.write_inst_en), 32'(tbl[i].e_wen));
            chk($sformatf("v%0d wdata", i), 32'(bus.write_inst_data), 32'(tbl[i].e_wd));
            chk($sformatf("v%0d waddr", i), 32'(bus.write_inst_addr), 32'(tbl[i].e_wa));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d mpu_reset", i), 32'(mpu_reset), 0);
            if (tbl[i].e_lc_chk)
                chk($sformatf("v%0d lc", i), 32'(load_count), 32'(tbl[i].e_lc));
        end
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        for (int a = 5; a < 64; a++) begin
            step();
            chk($sformatf("fill%0d wen", a), 32'(bus.write_inst_en), 1);
            chk($sformatf("fill%0d addr", a), 32'(bus.write_inst_addr), 32'(a));
            chk($sformatf("fill%0d data", a), 32'(bus.write_inst_data), 0);
        end
        chk("run0 busy", 32'(busy), 1);
        for (int k = 1; k < 10; k++) begin
            load_start = (k == 3);
            run_cycles = 16'd2;
            step();
            chk($sformatf("run%0d busy", k), 32'(busy), 1);
            chk($sformatf("run%0d done", k), 32'(done), 0);
            chk($sformatf("run%0d wen", k), 32'(bus.write_inst_en), 0);
            chk($sformatf("run%0d rdy", k), 32'(bus.in_ready), 0);
        end
        load_start = 1'b0;
        step();
        chk("seq1 done", 32'(done), 1);
        chk("seq1 busy", 32'(busy), 0);
        chk("seq1 lc", 32'(load_count), 3);
        chk("seq1 trunc", 32'(load_trunc), 0);

        // 64 beats, in_last on the 64th: no fill
        load_start = 1'b1;
        run_cycles = 16'd2;
        step();
        load_start = 1'b0;
        chk("s2 rdy", 32'(bus.in_ready), 1);
        chk("s2 lc0", 32'(load_count), 0);
        for (int i = 0; i < 64; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pat(i);
            bus.in_last  = (i == 63);
            step();
            chk($sformatf("s2 b%0d wen", i), 32'(bus.write_inst_en), 1);
            chk($sformatf("s2 b%0d addr", i), 32'(bus.write_inst_addr), 32'(i));
            chk($sformatf("s2 b%0d data", i), 32'(bus.write_inst_data), 32'(pat(i)));
        end
        chk("s2 rdy end", 32'(bus.in_ready), 0);
        chk("s2 lc", 32'(load_count), 64);
        chk("s2 trunc", 32'(load_trunc), 0);
        bus.in_last = 1'b0;
        step();
        chk("s2 nofill wen", 32'(bus.write_inst_en), 0);
        chk("s2 run busy", 32'(busy), 1);
        bus.in_valid = 1'b0;
        step();
        chk("s2 done", 32'(done), 1);

        // 64 beats, in_last never set: truncated, beat 65 refused
        load_start = 1'b1;
        run_cycles = 16'd1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pat(i + 100);
            bus.in_last  = 1'b0;
            step();
            chk($sformatf("s3 b%0d addr", i), 32'(bus.write_inst_addr), 32'(i));
        end
        chk("s3 trunc", 32'(load_trunc), 1);
        chk("s3 lc", 32'(load_count), 64);
        chk("s3 rdy", 32'(bus.in_ready), 0);
        bus.in_data = D;
        step();
        chk("s3 b65 wen", 32'(bus.write_inst_en), 0);
        chk("s3 b65 lc", 32'(load_count), 64);
        chk("s3 done", 32'(done), 1);
        chk("s3 trunc sticky", 32'(load_trunc), 1);
        bus.in_valid = 1'b0;

        // run_cycles = 0: fill straight into DONE, restart clears counters
        load_start = 1'b1;
        run_cycles = 16'd0;
        step();
        load_start = 1'b0;
        chk("s4 lc0", 32'(load_count), 0);
        chk("s4 trunc0", 32'(load_trunc), 0);
        chk("s4 rdy", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data  = C;
        bus.in_last  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("s4 b0 data", 32'(bus.write_inst_data), 32'(C));
        chk("s4 lc1", 32'(load_count), 1);
        for (int a = 1; a < 64; a++) begin
            step();
            chk($sformatf("s4 f%0d addr", a), 32'(bus.write_inst_addr), 32'(a));
            chk($sformatf("s4 f%0d busy", a), 32'(busy), 32'(a < 63));
            chk($sformatf("s4 f%0d done", a), 32'(done), 32'(a == 63));
        end
        step();
        chk("s4 stays done", 32'(done), 1);
        chk("s4 lc hold", 32'(load_count), 1);

        // reset in the middle of a fill
        load_start = 1'b1;
        run_cycles = 16'd5;
        step();
        load_start   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = A;
        bus.in_last  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int a = 1; a <= 20; a++) step();
        chk("s5 pre addr", 32'(bus.write_inst_addr), 20);
        chk("s5 pre wen", 32'(bus.write_inst_en), 1);
        reset_n = 1'b0;
        #1;
        chk("s5 wen", 32'(bus.write_inst_en), 0);
        chk("s5 addr", 32'(bus.write_inst_addr), 0);
        chk("s5 data", 32'(bus.write_inst_data), 0);
        chk("s5 mpu_reset", 32'(mpu_reset), 1);
        chk("s5 rdy", 32'(bus.in_ready), 0);
        chk("s5 busy", 32'(busy), 0);
        chk("s5 done", 32'(done), 0);
        chk("s5 lc", 32'(load_count), 0);
        chk("s5 trunc", 32'(load_trunc), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("s5 post wen", 32'(bus.write_inst_en), 0);
        chk("s5 post mpu_reset", 32'(mpu_reset), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpu_program_sequencer.md
MPU_PROGRAM_SEQUENCER -- requirements
Module: mpu_program_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 25, instruction word width.
REQ-002 SHALL have parameter OPCODE_COUNT, default 64, instruction memory depth; AW = $clog2(OPCODE_COUNT).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, run-cycle counter width.
REQ-004 One clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  async active-low reset.
REQ-006 load_start  input  1  one-cycle request to begin a load/run sequence.
REQ-007 run_cycles  input  CNT_WIDTH  cycles to run after load; sampled on accepted load_start.
REQ-008 in_valid  input  1  instruction beat valid.
REQ-009 in_data  input  OPCODE_WIDTH  instruction beat.
REQ-010 in_last  input  1  final beat of program.
REQ-011 in_ready  output  1  sequencer accepts beat.
REQ-012 write_inst_en  output  1  MPU instruction-memory write enable.
REQ-013 write_inst_data  output  OPCODE_WIDTH  MPU write data.
REQ-014 write_inst_addr  output  AW  MPU write address.
REQ-015 mpu_reset  output  1  active-high reset to MPU pipeline.
REQ-016 busy  output  1  state is LOAD, FILL or RUN.
REQ-017 done  output  1  state is DONE.
REQ-018 load_count  output  AW+1  program words received in current sequence.
REQ-019 load_trunc  output  1  sticky: load ended at depth without in_last.

Function
REQ-020 States SHALL be IDLE, LOAD, FILL, RUN, DONE; one-hot or binary encoding free.
REQ-021 load_start SHALL be accepted only in IDLE or DONE; ignored elsewhere.
REQ-022 Accepted load_start SHALL: go LOAD, latch run_cycles, clear load_count, load_trunc, write pointer to 0.
REQ-023 mpu_reset SHALL be 1 iff state is IDLE; MPU therefore runs from LOAD onward.
REQ-024 in_ready SHALL be 1 iff state is LOAD; beat transfers when in_valid and in_ready both 1.
REQ-025 Each transfer SHALL register a write: next cycle write_inst_en=1, write_inst_data=in_data, write_inst_addr=pointer; pointer and load_count increment.
REQ-026 write_inst_en SHALL be 0 in any cycle following no transfer/fill; data/addr hold last values.
REQ-027 Transfer with in_last=1 at pointer < OPCODE_COUNT-1 SHALL go FILL.
REQ-028 Transfer at pointer = OPCODE_COUNT-1 SHALL end load regardless of in_last; load_trunc set if in_last=0.
REQ-029 FILL SHALL write 0 (NOP) to each remaining address, one per cycle, ascending through OPCODE_COUNT-1, then go RUN.
REQ-030 Load ending at OPCODE_COUNT-1 SHALL go directly RUN; no FILL.
REQ-031 RUN SHALL count latched run_cycles cycles, then go DONE; run_cycles=0 SHALL skip RUN (load/fill end -> DONE).
REQ-032 Pointer SHALL never wrap; no write issued beyond OPCODE_COUNT-1.
REQ-033 load_count SHALL exclude FILL writes and hold through RUN/DONE until next accepted load_start.
REQ-034 In_valid outside LOAD SHALL be ignored and not written.

Reset
REQ-035 On reset_n=0, asynchronously: state IDLE, mpu_reset=1, in_ready=0, write_inst_en=0, write_inst_data=0, write_inst_addr=0, busy=0, done=0, load_count=0, load_trunc=0, counters 0.
REQ-036 Reset mid-LOAD/FILL/RUN SHALL abort immediately with no further writes; partial memory contents are not restored.

Verification
REQ-037 3-beat program (A,B,C; last on C), run_cycles=10 -> writes A@0,B@1,C@2, zeros @3..63 over 61 cycles, load_count=3, 10 RUN cycles, done=1.
REQ-038 64 beats, in_last only on 64th -> writes @0..63, no FILL, load_trunc=0, in_ready=0 after 64th beat.
REQ-039 64 beats, in_last never set -> load ends at addr 63, load_trunc=1, beat 65 not accepted.
REQ-040 in_valid toggled with gaps, load_start pulsed during RUN -> writes only on transfers, addresses contiguous, load_start ignored.
REQ-041 run_cycles=0, single last beat -> FILL then DONE directly, busy never high in RUN; new load_start from DONE restarts with load_count=0.
REQ-042 reset_n low during FILL at addr 20 -> same cycle write_inst_en=0, mpu_reset=1, state IDLE, all outputs at reset values.
